dimmer_key_ctrl: RTL

//  Front-end controller for the PWM dimmer. Synchronises and debounces the raw KEY0/KEY1

---
 rtl/dimmer_key_ctrl.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/dimmer_key_ctrl.sv
// dimmer_key_ctrl
//   Key front-end for the PWM dimmer. Each raw key passes through a 2-FF
//   synchroniser and a debouncer. An arbitration FSM then turns debounced
//   up/down presses into single steps with press-and-hold auto-repeat. The
//   FSM owns the saturating brightness register.
//
// Ports
//   clock_50  in   system clock
//   clr       in   synchronous reset, active-high
//   up_n      in   raw KEY0, active-low, asynchronous
//   down_n    in   raw KEY1, active-low, asynchronous
//   test      in   1 = all timings divided by TEST_DIV
//   level     out  brightness step, 0..LEVEL_MAX
//   step_up   out  one-cycle pulse per actual increment
//   step_dn   out  one-cycle pulse per actual decrement
//   at_max    out  level == LEVEL_MAX
//   at_min    out  level == 0
module dimmer_key_ctrl #(
  parameter int unsigned LEVEL_W      = 4,
  parameter int unsigned LEVEL_MAX    = 15,
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned HOLD_CYC     = 25000000,
  parameter int unsigned REPEAT_CYC   = 5000000,
  parameter int unsigned TEST_DIV     = 10
) (
  input  logic               clock_50,
  input  logic               clr,
  input  logic               up_n,
  input  logic               down_n,
  input  logic               test,
  output logic [LEVEL_W-1:0] level,
  output logic               step_up,
  output logic               step_dn,
  output logic               at_max,
  output logic               at_min
);

  // Counter widths sized to hold the full (undivided) thresholds.
  localparam int unsigned DB_RAW_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned DB_W      = (DB_RAW_W < 1) ? 1 : DB_RAW_W;
  localparam int unsigned TMR_MAX   = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int unsigned TMR_RAW_W = $clog2(TMR_MAX + 1);
  localparam int unsigned TMR_W     = (TMR_RAW_W < 1) ? 1 : TMR_RAW_W;

  // Divided thresholds for test mode.
  localparam int unsigned DB_TEST   = DEBOUNCE_CYC / TEST_DIV;
  localparam int unsigned HOLD_TEST = HOLD_CYC / TEST_DIV;
  localparam int unsigned RPT_TEST  = REPEAT_CYC / TEST_DIV;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UP_HOLD,
    S_UP_RPT,
    S_DN_HOLD,
    S_DN_RPT,
    S_LOCK
  } state_e;

  // Key vectors: bit 0 = up, bit 1 = down. Synchroniser and debounced
  // values use raw polarity (1 = released).
  logic [1:0]         sync1_q, sync1_d;
  logic [1:0]         sync2_q, sync2_d;
  logic [1:0]         key_db_q, key_db_d;
  logic [DB_W-1:0]    db_cnt_q [2];
  logic [DB_W-1:0]    db_cnt_d [2];

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               step_up_q, step_up_d;
  logic               step_dn_q, step_dn_d;
  logic               at_max_q, at_max_d;
  logic               at_min_q, at_min_d;

  logic [DB_W-1:0]    db_thr;
  logic [TMR_W-1:0]   hold_thr;
  logic [TMR_W-1:0]   rpt_thr;
  logic [TMR_W:0]     tmr_inc;
  logic               hold_hit;
  logic               rpt_hit;
  logic               up_p;
  logic               dn_p;
  logic               req_up;
  logic               req_dn;

  // Effective thresholds follow test every cycle.
  always_comb begin
    db_thr   = test ? DB_W'(DB_TEST)    : DB_W'(DEBOUNCE_CYC);
    hold_thr = test ? TMR_W'(HOLD_TEST) : TMR_W'(HOLD_CYC);
    rpt_thr  = test ? TMR_W'(RPT_TEST)  : TMR_W'(REPEAT_CYC);
  end

  // Synchronisers and debouncers. A flip needs db_thr consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    sync1_d  = {down_n, up_n};
    sync2_d  = sync1_q;
    key_db_d = key_db_q;
    for (int k = 0; k < 2; k++) begin
      logic [DB_W:0] db_inc;
      db_inc      = {1'b0, db_cnt_q[k]} + (DB_W + 1)'(1);
      db_cnt_d[k] = '0;
      if (sync2_q[k] != key_db_q[k]) begin
        if (db_inc >= {1'b0, db_thr}) begin
          key_db_d[k] = sync2_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
        end
      end
    end
  end

  assign up_p = ~key_db_q[0];
  assign dn_p = ~key_db_q[1];

  // Timer compare uses one extra bit so a counter left above a freshly
  // lowered threshold still fires on the next cycle.
  assign tmr_inc  = {1'b0, tmr_q} + (TMR_W + 1)'(1);
  assign hold_hit = tmr_inc >= {1'b0, hold_thr};
  assign rpt_hit  = tmr_inc >= {1'b0, rpt_thr};

  // Arbitration FSM: step requests, hold/repeat timing, lockout.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    req_up  = 1'b0;
    req_dn  = 1'b0;
    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (up_p && dn_p) begin
          state_d = S_LOCK;
        end else if (up_p) begin
          state_d = S_UP_HOLD;
          req_up  = 1'b1;
        end else if (dn_p) begin
          state_d = S_DN_HOLD;
          req_dn  = 1'b1;
        end
      end
      S_UP_HOLD, S_UP_RPT: begin
        // Release takes priority over the other key.
        if (!up_p) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end else if (dn_p) begin
          state_d = S_LOCK;
          tmr_d   = '0;
        end else if ((state_q == S_UP_HOLD) ? hold_hit : rpt_hit) begin
          state_d = S_UP_RPT;
          tmr_d   = '0;
          req_up  = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_DN_HOLD, S_DN_RPT: begin
        if (!dn_p) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end else if (up_p) begin
          state_d = S_LOCK;
          tmr_d   = '0;
        end else if ((state_q == S_DN_HOLD) ? hold_hit : rpt_hit) begin
          state_d = S_DN_RPT;
          tmr_d   = '0;
          req_dn  = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_LOCK: begin
        tmr_d = '0;
        if (!up_p && !dn_p) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // Saturating level register; a blocked request yields no pulse.
  always_comb begin
    level_d   = level_q;
    step_up_d = 1'b0;
    step_dn_d = 1'b0;
    if (req_up && (level_q != LEVEL_W'(LEVEL_MAX))) begin
      level_d   = level_q + LEVEL_W'(1);
      step_up_d = 1'b1;
    end else if (req_dn && (level_q != '0)) begin
      level_d   = level_q - LEVEL_W'(1);
      step_dn_d = 1'b1;
    end
    at_max_d = (level_d == LEVEL_W'(LEVEL_MAX));
    at_min_d = (level_d == '0);
  end

  always_ff @(posedge clock_50) begin
    if (clr) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      key_db_q  <= 2'b11;
      for (int k = 0; k < 2; k++) begin
        db_cnt_q[k] <= '0;
      end
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      level_q   <= '0;
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
      at_max_q  <= 1'b0;
      at_min_q  <= 1'b1;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      key_db_q  <= key_db_d;
      for (int k = 0; k < 2; k++) begin
        db_cnt_q[k] <= db_cnt_d[k];
      end
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      level_q   <= level_d;
      step_up_q <= step_up_d;
      step_dn_q <= step_dn_d;
      at_max_q  <= at_max_d;
      at_min_q  <= at_min_d;
    end
  end

  assign level   = level_q;
  assign step_up = step_up_q;
  assign step_dn = step_dn_q;
  assign at_max  = at_max_q;
  assign at_min  = at_min_q;

endmodule
